// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
//   Round-robin arbiter and sequencer that shares the single-port command RAM
//   between NREQ requesters. A granted transaction is serialised into two RAM
//   command words (address word, gap cycle, data/read word); reads then wait
//   for ram_tx_valid. Completion is reported with a one-cycle done pulse.
//
//   Optional feature macro: RAM_ARB_TIMEOUT_EN
//     defined     : WAIT_RD gives up after TIMEOUT_CYCLES, done with err=1, rdata=0
//     not defined : WAIT_RD waits indefinitely, err is tied low
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req             per-requester request, held until gnt
//   req_we          1 = write, 0 = read
//   req_addr        packed addresses, requester i at [ADDR_W*i +: ADDR_W]
//   req_wdata       packed write data, same packing
//   gnt             one-hot pulse: request accepted, fields sampled
//   done            one-hot pulse: transaction complete
//   rdata           read data, valid with done, held until the next read
//   err             read timeout flag, valid with done
//   busy            high whenever the sequencer is not idle
//   ram_din         RAM command word {opcode[1:0], payload}
//   ram_rx_valid    RAM command word strobe
//   ram_dout        RAM read data
//   ram_tx_valid    RAM read data valid
module ram_access_arbiter #(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*ADDR_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [ADDR_W-1:0]        rdata,
    output logic                     err,
    output logic                     busy,
    output logic [ADDR_W+1:0]        ram_din,
    output logic                     ram_rx_valid,
    input  logic [ADDR_W-1:0]        ram_dout,
    input  logic                     ram_tx_valid
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // RAM command opcodes
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_CMD  = 2'b11;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_GAP     = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_WAIT_RD = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // Elaboration-time guard against unsupported configurations
    if (NREQ < 2 || NREQ > 8 || ADDR_W != 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ram_access_arbiter: unsupported parameter set");
    end

    typedef struct packed {
        logic              we;
        logic [IDX_W-1:0]  idx;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] wdata;
    } txn_t;

    logic [2:0]        state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr, rr_nxt;
    txn_t              txn_q, txn_nxt;
    logic [NREQ-1:0]   gnt_nxt, done_nxt;
    logic [ADDR_W-1:0] rdata_nxt;
    logic [ADDR_W+1:0] din_nxt;
    logic              rx_nxt;
    logic              busy_nxt;

    logic              arb_found;
    logic [IDX_W-1:0]  arb_idx;
    logic [IDX_W-1:0]  cand;

    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [ADDR_W-1:0] wdata_arr [NREQ];

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic              err_nxt;
`else
    assign err = 1'b0;
`endif

    // Unpack the per-requester address and data buses
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*ADDR_W +: ADDR_W];
    end

    // Round-robin pick: first set req bit after rr_ptr, wrapping around
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((32'(rr_ptr) + k) % NREQ);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic; outputs describe the current state's action
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        txn_nxt   = txn_q;
        gnt_nxt   = '0;
        done_nxt  = '0;
        rdata_nxt = rdata;
        din_nxt   = ram_din;
        rx_nxt    = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
        err_nxt    = err;
        to_cnt_nxt = to_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_nxt       = NREQ'(1) << arb_idx;
                    txn_nxt.we    = req_we[arb_idx];
                    txn_nxt.idx   = arb_idx;
                    txn_nxt.addr  = addr_arr[arb_idx];
                    txn_nxt.wdata = wdata_arr[arb_idx];
                    rr_nxt        = arb_idx;
                    state_nxt     = S_ADDR;
`ifdef RAM_ARB_TIMEOUT_EN
                    err_nxt       = 1'b0;
`endif
                end
            end
            S_ADDR: begin
                rx_nxt    = 1'b1;
                din_nxt   = txn_q.we ? {OP_WR_ADDR, txn_q.addr} : {OP_RD_ADDR, txn_q.addr};
                state_nxt = S_GAP;
            end
            S_GAP: begin
                // Keeps ram_rx_valid from being high on back-to-back cycles
                state_nxt = S_DATA;
            end
            S_DATA: begin
                rx_nxt = 1'b1;
                if (txn_q.we) begin
                    din_nxt   = {OP_WR_DATA, txn_q.wdata};
                    state_nxt = S_DONE;
                end else begin
                    din_nxt   = {OP_RD_CMD, ADDR_W'(0)};
                    state_nxt = S_WAIT_RD;
                end
`ifdef RAM_ARB_TIMEOUT_EN
                to_cnt_nxt = '0;
`endif
            end
            S_WAIT_RD: begin
                if (ram_tx_valid) begin
                    rdata_nxt = ram_dout;
                    state_nxt = S_DONE;
`ifdef RAM_ARB_TIMEOUT_EN
                    err_nxt   = 1'b0;
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_nxt = '0;
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
`endif
                end
            end
            S_DONE: begin
                done_nxt  = NREQ'(1) << txn_q.idx;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rr_ptr       <= IDX_W'(NREQ - 1);
            txn_q        <= '0;
            gnt          <= '0;
            done         <= '0;
            rdata        <= '0;
            busy         <= 1'b0;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
            err          <= 1'b0;
            to_cnt       <= '0;
`endif
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_nxt;
            txn_q        <= txn_nxt;
            gnt          <= gnt_nxt;
            done         <= done_nxt;
            rdata        <= rdata_nxt;
            busy         <= busy_nxt;
            ram_din      <= din_nxt;
            ram_rx_valid <= rx_nxt;
`ifdef RAM_ARB_TIMEOUT_EN
            err          <= err_nxt;
            to_cnt       <= to_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter
//   Self-checking bench for ram_access_arbiter: directed scenarios with literal
//   expectations plus a randomized phase, all outputs compared every cycle
//   against a transaction-level model (age of the current transaction since
//   its grant, round-robin pointer, held read data).
`timescale 1ns/1ps
module tb_ram_access_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 8;
    localparam int TMO  = 16;
    localparam int IW   = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NREQ-1:0]   req, req_we;
    logic [AW-1:0]     t_addr  [NREQ];
    logic [AW-1:0]     t_wdata [NREQ];
    logic [NREQ*AW-1:0] req_addr, req_wdata;
    logic [NREQ-1:0]   gnt, done;
    logic [AW-1:0]     rdata;
    logic              err, busy;
    logic [AW+1:0]     ram_din;
    logic              ram_rx_valid;
    logic [AW-1:0]     ram_dout;
    logic              ram_tx_valid;

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_addr[g*AW +: AW]  = t_addr[g];
        assign req_wdata[g*AW +: AW] = t_wdata[g];
    end

    ram_access_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .err(err), .busy(busy), .ram_din(ram_din),
        .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_age;      // cycles since grant, -1 = no transaction
    int            m_done_at;  // age at which done shows, -1 = not yet known
    int            m_rr;
    int            m_idx;
    bit            m_we;
    logic [AW-1:0] m_addr, m_wdata;
    logic [NREQ-1:0] e_gnt, e_done;
    logic [AW-1:0] e_rdata;
    logic          e_err, e_busy, e_rx;
    logic [AW+1:0] e_din;

    task automatic model_reset();
        m_age = -1; m_done_at = -1; m_rr = NREQ - 1; m_idx = 0;
        m_we = 1'b0; m_addr = '0; m_wdata = '0;
        e_gnt = '0; e_done = '0; e_rdata = '0; e_err = 1'b0;
        e_busy = 1'b0; e_rx = 1'b0; e_din = '0;
    endtask

    // Predict next-cycle outputs from this cycle's inputs
    task automatic model_step();
        bit idle_now;
        idle_now = (m_age < 0) || (m_age == m_done_at);
        e_gnt  = '0;
        e_done = '0;
        e_rx   = 1'b0;
        if (!idle_now) begin
            if (!m_we && m_done_at < 0 && m_age >= 3) begin
                if (ram_tx_valid) begin
                    e_rdata = ram_dout; e_err = 1'b0; m_done_at = m_age + 2;
                end
`ifdef RAM_ARB_TIMEOUT_EN
                else if (m_age == 3 + TMO - 1) begin
                    e_rdata = '0; e_err = 1'b1; m_done_at = m_age + 2;
                end
`endif
            end
            m_age++;
            if (m_age == 1) begin
                e_din = {(m_we ? 2'b00 : 2'b10), m_addr}; e_rx = 1'b1;
            end else if (m_age == 3) begin
                e_din = m_we ? {2'b01, m_wdata} : {2'b11, 8'h00}; e_rx = 1'b1;
            end
            if (m_age == m_done_at) begin
                e_done = NREQ'(1) << m_idx; e_busy = 1'b0;
            end else begin
                e_busy = 1'b1;
            end
        end else begin
            e_busy = 1'b0;
            m_age  = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                logic [IW-1:0] ii;
                i  = (m_rr + k) % NREQ;
                ii = IW'(i);
                if (m_age < 0 && req[ii]) begin
                    m_idx = i; m_we = req_we[ii]; m_addr = t_addr[ii]; m_wdata = t_wdata[ii];
                    m_rr = i; m_age = 0; m_done_at = m_we ? 4 : -1;
                    e_gnt = NREQ'(1) << i; e_busy = 1'b1; e_err = 1'b0;
                end
            end
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        check("m_gnt",   32'(gnt),          32'(e_gnt));
        check("m_done",  32'(done),         32'(e_done));
        check("m_rdata", 32'(rdata),        32'(e_rdata));
        check("m_err",   32'(err),          32'(e_err));
        check("m_busy",  32'(busy),         32'(e_busy));
        check("m_din",   32'(ram_din),      32'(e_din));
        check("m_rx",    32'(ram_rx_valid), 32'(e_rx));
        if (rst_n) model_step();
    end

    // ---------------- directed helpers ----------------
    task automatic wait_gnt(input int idx, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (((32'(gnt) >> idx) & 32'd1) != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_write(input int idx, input logic [7:0] a, input logic [7:0] d, input string tag);
        bit ok;
        logic [IW-1:0] ii;
        ii = IW'(idx);
        @(posedge clk); #1;
        req[ii] = 1'b1; req_we[ii] = 1'b1; t_addr[ii] = a; t_wdata[ii] = d;
        wait_gnt(idx, ok);
        check({tag, "_gnt_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, "_gnt_onehot"}, 32'(gnt), 32'd1 << idx);
            @(posedge clk); #1 req[ii] = 1'b0;
            @(negedge clk);
            check({tag, "_din_addr"}, 32'(ram_din), 32'({2'b00, a}));
            check({tag, "_rx_t1"}, 32'(ram_rx_valid), 32'd1);
            @(negedge clk);
            check({tag, "_rx_t2"}, 32'(ram_rx_valid), 32'd0);
            @(negedge clk);
            check({tag, "_din_data"}, 32'(ram_din), 32'({2'b01, d}));
            check({tag, "_rx_t3"}, 32'(ram_rx_valid), 32'd1);
            @(negedge clk);
            check({tag, "_done_t4"}, 32'(done), 32'd1 << idx);
        end else begin
            req[ii] = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int order [4];
        int n;
        req = '0; req_we = '0;
        t_addr = '{default: '0}; t_wdata = '{default: '0};
        ram_dout = '0; ram_tx_valid = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_din", 32'(ram_din), 32'd0);

        // 1: write requester 0
        run_write(0, 8'h02, 8'h33, "t1");

        // 2: read requester 1, data returned two cycles after the read command word
        @(posedge clk); #1;
        req[1] = 1'b1; req_we[1] = 1'b0; t_addr[1] = 8'h02;
        wait_gnt(1, ok);
        check("t2_gnt_seen", 32'(ok), 32'd1);
        if (ok) begin
            @(posedge clk); #1 req[1] = 1'b0;
            @(negedge clk);
            check("t2_din_addr", 32'(ram_din), 32'h202);
            @(negedge clk);
            @(negedge clk);
            check("t2_din_cmd", 32'(ram_din), 32'h300);
            @(posedge clk); #1;
            @(posedge clk); #1 ram_tx_valid = 1'b1; ram_dout = 8'h33;
            @(posedge clk); #1 ram_tx_valid = 1'b0; ram_dout = 8'h00;
            @(negedge clk);
            check("t2_done_early", 32'(done), 32'd0);
            @(negedge clk);
            check("t2_done", 32'(done), 32'h2);
            check("t2_rdata", 32'(rdata), 32'h33);
            check("t2_err", 32'(err), 32'd0);
        end else begin
            req[1] = 1'b0;
        end

        // 3: both requesters held -> alternating grants
        @(posedge clk); #1;
        req_we = '1;
        t_addr[0] = 8'h10; t_wdata[0] = 8'($urandom);
        t_addr[1] = 8'h20; t_wdata[1] = 8'($urandom);
        req = 2'b11;
        order = '{default: -1};
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                order[n] = (gnt == 2'b01) ? 0 : (gnt == 2'b10) ? 1 : 99;
                n++;
            end
        end
        @(posedge clk); #1 req = '0;
        check("t3_count", 32'(n), 32'd4);
        check("t3_order0", 32'(order[0]), 32'd0);
        check("t3_order1", 32'(order[1]), 32'd1);
        check("t3_order2", 32'(order[2]), 32'd0);
        check("t3_order3", 32'(order[3]), 32'd1);

        // 4: spurious ram_tx_valid while idle, then a write
        wait_idle(ok);
        check("t4_idle", 32'(ok), 32'd1);
        @(posedge clk); #1 ram_tx_valid = 1'b1; ram_dout = 8'hA5;
        @(posedge clk); #1 ram_tx_valid = 1'b0; ram_dout = 8'h00;
        run_write(1, 8'h05, 8'h66, "t4");
        check("t4_rdata_kept", 32'(rdata), 32'h33);

`ifdef RAM_ARB_TIMEOUT_EN
        // Read with no RAM response -> timeout
        @(posedge clk); #1;
        req[0] = 1'b1; req_we[0] = 1'b0; t_addr[0] = 8'h07;
        wait_gnt(0, ok);
        check("to_gnt_seen", 32'(ok), 32'd1);
        @(posedge clk); #1 req[0] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < TMO + 20; c++) begin
            @(negedge clk);
            if (done[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check("to_done_seen", 32'(ok), 32'd1);
        check("to_err", 32'(err), 32'd1);
        check("to_rdata", 32'(rdata), 32'd0);
        check("to_idle", 32'(busy), 32'd0);
`endif

        // 5: asynchronous reset in the gap cycle
        @(posedge clk); #1;
        req[1] = 1'b1; req_we[1] = 1'b1; t_addr[1] = 8'h09; t_wdata[1] = 8'h77;
        wait_gnt(1, ok);
        check("t5_gnt_seen", 32'(ok), 32'd1);
        @(posedge clk); #1 req[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_din", 32'(ram_din), 32'd0);
        check("t5_rst_rx", 32'(ram_rx_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_outs", 32'({gnt, done, rdata, err}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t5_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        req_we = '1; t_addr[0] = 8'h0A; t_addr[1] = 8'h0B;
        req = 2'b11;
        wait_gnt(0, ok);
        check("t5_prio0", 32'(ok), 32'd1);
        check("t5_gnt_val", 32'(gnt), 32'h1);
        @(posedge clk); #1 req[0] = 1'b0;
        wait_gnt(1, ok);
        check("t5_then1", 32'(ok), 32'd1);
        @(posedge clk); #1 req[1] = 1'b0;

        // 6: randomized traffic with a randomly responding RAM
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                logic [IW-1:0] ii;
                ii = IW'(i);
                if (gnt[ii]) begin
                    req[ii] = 1'b0;
                end else if (!req[ii] && $urandom_range(0, 3) == 0) begin
                    req[ii]     = 1'b1;
                    req_we[ii]  = 1'($urandom_range(0, 1));
                    t_addr[ii]  = 8'($urandom);
                    t_wdata[ii] = 8'($urandom);
                end
            end
            ram_tx_valid = ($urandom_range(0, 3) == 0);
            ram_dout     = 8'($urandom);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            logic [IW-1:0] ii;
            ii = IW'(i);
            if (gnt[ii]) req[ii] = 1'b0;
        end
        ram_tx_valid = 1'b1;
        // Let pending requests and reads drain
        for (int c = 0; c < 200 && (req != '0 || busy); c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                logic [IW-1:0] ii;
                ii = IW'(i);
                if (gnt[ii]) req[ii] = 1'b0;
            end
        end
        ram_tx_valid = 1'b0;
        req = '0;
        wait_idle(ok);
        check("end_idle", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #(1_000_000);
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
